// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-ported register file.
// Holds the clear/ready FSM encoding and the address-width helper.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: set on issue, cleared by accepted writes, set wins on collision.
// Lookups are combinational from the registered busy vector.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = addr_width(NREGS)
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              set_en_i,
   input  logic [AW-1:0]     set_addr_i,
   input  logic [NWR-1:0]    clr_en_i,
   input  logic [NWR*AW-1:0] clr_addr_i,
   input  logic [NRD*AW-1:0] rd_addr_i,
   output logic [NRD-1:0]    rd_busy_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (clr_en_i[j]) busy_d[clr_addr_i[j*AW +: AW]] = 1'b0;
         end
         // Applied after the clears so an issue to a register being written keeps it busy.
         if (set_en_i) busy_d[set_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   always_comb begin
      rd_busy_o = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with self-clearing sequence and issue scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = addr_width(NREGS)
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_req,
   output logic                ready,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                sb_set_en,
   input  logic [AW-1:0]       sb_set_addr
);

   state_e         state_q;
   logic [AW-1:0]  clr_idx_q;
   logic           ready_q;
   logic [XLEN-1:0] mem_q [NREGS];
   logic           wr_ok;
   logic [NRD-1:0] sb_busy;

   // A clear request in READY drops that cycle's writes and issues.
   assign wr_ok = (state_q == READY) && !clear_req;
   assign ready = ready_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_idx_q <= clr_idx_q + 1'b1;
               if (clr_idx_q == AW'(NREGS - 1)) begin
                  state_q <= READY;
                  ready_q <= 1'b1;
               end
            end
            READY: begin
               if (clear_req) begin
                  state_q   <= CLEAR;
                  clr_idx_q <= '0;
                  ready_q   <= 1'b0;
               end
            end
            default: begin
               state_q   <= CLEAR;
               clr_idx_q <= '0;
               ready_q   <= 1'b0;
            end
         endcase
      end
   end

   // Array has no reset; the clear sequence is what initialises it.
   always_ff @(posedge clock) begin
      if (state_q == CLEAR) begin
         mem_q[clr_idx_q] <= '0;
      end else if (wr_ok) begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
               mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
         end
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) u_sb (
      .clock      (clock),
      .reset      (reset),
      .flush_i    ((state_q == READY) && clear_req),
      .set_en_i   (sb_set_en && wr_ok),
      .set_addr_i (sb_set_addr),
      .clr_en_i   (wr_en & {NWR{wr_ok}}),
      .clr_addr_i (wr_addr),
      .rd_addr_i  (rd_addr),
      .rd_busy_o  (sb_busy)
   );

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         if (ready_q && (rd_addr[k*AW +: AW] != '0)) begin
            rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
            rd_busy[k]              = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
               if (wr_ok && wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
                  rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                  rd_busy[k]              = 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (XLEN=32, NREGS=32, 2R/2W).
// Expectations adapt to whether REGFILE_BYPASS_EN is defined.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clock = 1'b0;
   logic                reset;
   logic                clear_req;
   logic                ready;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                sb_set_en;
   logic [AW-1:0]       sb_set_addr;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   regfile_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .clear_req   (clear_req),
      .ready       (ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr)
   );

   task automatic idle();
      clear_req   = 1'b0;
      wr_en       = '0;
      wr_addr     = '0;
      wr_data     = '0;
      sb_set_en   = 1'b0;
      sb_set_addr = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rd_addr = {5'd2, 5'd1};
      reset   = 1'b1;
      #3;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
      total++;
      if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", rd_busy); end
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rd_data); end
      step();
      step();
      reset = 1'b0;
      for (int i = 1; i <= NREGS; i++) begin
         step();
         total++;
         if (ready !== (i == NREGS)) begin
            bad++;
            $display("FAIL ready_edge%0d got=%b want=%b", i, ready, (i == NREGS));
         end
      end
      for (int a = 0; a < NREGS; a++) begin
         rd_addr = {5'(NREGS - 1 - a), 5'(a)};
         #1;
         total++;
         if (rd_data !== 64'h0) begin bad++; $display("FAIL init_read a=%0d got=%h want=0", a, rd_data); end
      end
   endtask

   task automatic test_write_priority();
      wr_en   = 2'b11;
      wr_addr = {5'd5, 5'd5};
      wr_data = {32'h12345678, 32'hDEADBEEF};
      step();
      idle();
      rd_addr = {5'd0, 5'd5};
      #1;
      total++;
      if (rd_data[31:0] !== 32'h12345678) begin
         bad++; $display("FAIL wr_priority got=%h want=12345678", rd_data[31:0]);
      end
   endtask

   task automatic test_x0();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd0};
      wr_data = {32'h0, 32'hFFFFFFFF};
      rd_addr = {5'd0, 5'd0};
      #1;
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL x0_same got=%h want=0", rd_data); end
      step();
      idle();
      #1;
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL x0_after got=%h want=0", rd_data); end
   endtask

   task automatic test_same_cycle();
      logic [31:0] exp_same;
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      wr_data = {32'h0, 32'h11111111};
      step();
      wr_data = {32'h0, 32'hA5A5A5A5};
      rd_addr = {5'd7, 5'd0};
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hA5A5A5A5;
`else
      exp_same = 32'h11111111;
`endif
      #1;
      total++;
      if (rd_data[63:32] !== exp_same) begin
         bad++; $display("FAIL same_cycle got=%h want=%h", rd_data[63:32], exp_same);
      end
      step();
      idle();
      #1;
      total++;
      if (rd_data[63:32] !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL after_write got=%h want=a5a5a5a5", rd_data[63:32]);
      end
   endtask

   task automatic test_scoreboard();
      rd_addr     = {5'd8, 5'd9};
      sb_set_en   = 1'b1;
      sb_set_addr = 5'd9;
      step();
      idle();
      #1;
      total++;
      if (rd_busy !== 2'b01) begin bad++; $display("FAIL sb_set got=%b want=01", rd_busy); end
      wr_en       = 2'b10;
      wr_addr     = {5'd9, 5'd0};
      wr_data     = {32'hCAFEF00D, 32'h0};
      sb_set_en   = 1'b1;
      sb_set_addr = 5'd9;
      step();
      idle();
      #1;
      total++;
      if (rd_busy !== 2'b01) begin bad++; $display("FAIL sb_set_wins got=%b want=01", rd_busy); end
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd9};
      wr_data = {32'h0, 32'h00000099};
      step();
      idle();
      #1;
      total++;
      if (rd_busy !== 2'b00) begin bad++; $display("FAIL sb_clear got=%b want=00", rd_busy); end
      total++;
      if (rd_data[31:0] !== 32'h00000099) begin
         bad++; $display("FAIL sb_wdata got=%h want=00000099", rd_data[31:0]);
      end
   endtask

   task automatic test_clear_reset();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd3};
      wr_data = {32'h0, 32'h00000055};
      step();
      idle();
      rd_addr = {5'd5, 5'd3};
      #1;
      total++;
      if (rd_data[31:0] !== 32'h00000055) begin
         bad++; $display("FAIL x3_load got=%h want=00000055", rd_data[31:0]);
      end
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b want=0", ready); end
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL clear_rdata got=%h want=0", rd_data); end
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      #1;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL midclear_reset got=%b want=0", ready); end
      step();
      reset = 1'b0;
      for (int i = 1; i <= NREGS; i++) begin
         step();
         if (i >= NREGS - 1) begin
            total++;
            if (ready !== (i == NREGS)) begin
               bad++; $display("FAIL rerun_edge%0d got=%b want=%b", i, ready, (i == NREGS));
            end
         end
      end
      #1;
      total++;
      if (rd_data !== 64'h0) begin bad++; $display("FAIL x3_cleared got=%h want=0", rd_data); end
   endtask

   initial begin
      reset   = 1'b1;
      rd_addr = '0;
      idle();
      test_reset();
      test_write_priority();
      test_x0();
      test_same_cycle();
      test_scoreboard();
      test_clear_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, number of registers; power of two, at least 4.
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports.
REQ-004 The block SHALL have parameter NWR, default 2, number of write ports.
REQ-005 The block SHALL define AW as clog2(NREGS), a derived local constant.
REQ-006 The block SHALL have port clock, input, 1 bit: all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 The block SHALL have port clear_req, input, 1 bit: request a full register-file clear.
REQ-009 The block SHALL have port ready, output, 1 bit: array initialised and accepting writes.
REQ-010 The block SHALL have port rd_addr, input, NRD*AW bits: read addresses, port k at slice k.
REQ-011 The block SHALL have port rd_data, output, NRD*XLEN bits: combinational read data.
REQ-012 The block SHALL have port rd_busy, output, NRD bits: addressed register has a pending producer.
REQ-013 The block SHALL have port wr_en, input, NWR bits: per-port write enable.
REQ-014 The block SHALL have port wr_addr, input, NWR*AW bits: write addresses.
REQ-015 The block SHALL have port wr_data, input, NWR*XLEN bits: write data.
REQ-016 The block SHALL have port sb_set_en, input, 1 bit: mark sb_set_addr busy (instruction issued).
REQ-017 The block SHALL have port sb_set_addr, input, AW bits: scoreboard set address.

Function
REQ-018 The block SHALL implement a two-state FSM with states CLEAR and READY; ready SHALL be 1 only in READY.
REQ-019 In CLEAR, each rising edge SHALL write 0 to entry clr_idx and increment clr_idx; at clr_idx==NREGS-1 the FSM SHALL go to READY, so ready rises exactly NREGS edges after CLEAR entry.
REQ-020 In READY, clear_req=1 at a rising edge SHALL move the FSM to CLEAR with clr_idx=0 and all busy bits 0; writes in that same cycle SHALL be dropped.
REQ-021 In CLEAR, wr_en and sb_set_en SHALL be ignored, rd_data SHALL be 0, rd_busy SHALL be 0, and clear_req SHALL be ignored (no restart).
REQ-022 In READY, a write with wr_en[j]=1 SHALL update entry wr_addr[j] on the rising edge; writes to address 0 SHALL be discarded.
REQ-023 Reads of address 0 SHALL always return 0 and rd_busy 0.
REQ-024 When several write ports target the same address in one cycle, the highest-numbered port SHALL win.
REQ-025 Scoreboard: sb_set_en SHALL set busy[sb_set_addr] (not for address 0); any accepted write SHALL clear busy[wr_addr[j]]; if set and clear hit the same address in one cycle, set SHALL win.
REQ-026 rd_busy[k] SHALL equal busy[rd_addr[k]] as registered; reads SHALL have zero-cycle latency.

Reset
REQ-027 Assertion of reset SHALL immediately force state CLEAR, clr_idx 0, all busy bits 0, ready 0, rd_busy 0, rd_data 0; array contents are not cleared asynchronously.
REQ-028 After reset deassertion, the clear sequence of REQ-019 SHALL run; ready SHALL rise after NREGS rising edges.
REQ-029 Reset asserted mid-clear or mid-operation SHALL restart the sequence from clr_idx 0.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, in READY a read whose address matches an enabled write in the same cycle SHALL return that wr_data (highest matching port) and rd_busy SHALL be 0 for it.
REQ-031 Without REGFILE_BYPASS_EN, reads SHALL return the stored value; written data SHALL be visible from the cycle after the write edge.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, READY), default XLEN/NREGS constants, and an address-width function.
REQ-033 Sub-module regfile_scoreboard SHALL own the busy vector, its set/clear priority and the rd_busy lookup.

Verification
REQ-034 Reset, then release: ready=0 for 32 edges, 1 after; all reads return 0.
REQ-035 Write port0 x5=0xDEADBEEF and port1 x5=0x12345678 in one cycle: next cycle x5 reads 0x12345678.
REQ-036 Write x0=0xFFFFFFFF and read x0: returns 0, with and without REGFILE_BYPASS_EN.
REQ-037 Same-cycle write x7=0xA5A5A5A5 and read x7: returns 0xA5A5A5A5 with bypass, old value without.
REQ-038 sb_set x9, then next cycle write x9 together with sb_set x9: rd_busy stays 1; a later write alone clears it.
REQ-039 Pulse clear_req after loading x3=0x55, then assert reset at clr_idx=10: ready stays 0 for 32 edges after release, and x3 reads 0.
